// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg: shared types and defaults for the 8x8 flash array sequencer.
//   - op_t     : command opcodes (READ / PROGRAM / ERASE / NOP)
//   - state_t  : sequencer states
//   - cmd_t    : registered command (op, row, data)
//   - drive_t  : all array-side digital enables, registered as one bundle
//   - drive_of : array drives implied by a state and the command being run
package flash_ctrl_pkg;

    localparam int T_SETUP_DEF   = 4;
    localparam int T_PGM_DEF     = 16;
    localparam int T_ERS_DEF     = 32;
    localparam int T_SENSE_DEF   = 4;
    localparam int T_RECOV_DEF   = 2;
    localparam int MAX_RETRY_DEF = 3;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_NOP     = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_PULSE, ST_SENSE1, ST_SENSE2, ST_LATCH, ST_RECOV, ST_DONE
    } state_t;

    typedef struct packed {
        op_t        op;
        logic [2:0] row;   // [2] = block, [1:0] = word line
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic [1:0] ssl_en;
        logic [1:0] gsl_en;
        logic [7:0] wl_sel;
        logic [7:0] bl_en;
        logic       hv_pgm;
        logic       hv_ers;
        logic       sen1;
        logic       sen2;
        logic [3:0] out_en;
    } drive_t;

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic drive_t drive_of(state_t st, cmd_t cmd);
        drive_t d;
        logic   sel;
        d   = '0;
        // Selects stay up from SETUP through LATCH so the string path is
        // stable for the whole pulse or sense window.
        sel = (cmd.op != OP_NOP) &&
              (st inside {ST_SETUP, ST_PULSE, ST_SENSE1, ST_SENSE2, ST_LATCH});
        if (sel) begin
            d.ssl_en[cmd.row[2]] = 1'b1;
            d.gsl_en[cmd.row[2]] = 1'b1;
            // Erase works on the whole block through the well, no WL select.
            if (cmd.op != OP_ERASE) d.wl_sel[cmd.row] = 1'b1;
        end
        case (st)
            ST_PULSE: begin
                if (cmd.op == OP_PROGRAM) begin
                    d.hv_pgm = 1'b1;
                    d.bl_en  = ~cmd.data;
                end else if (cmd.op == OP_ERASE) begin
                    d.hv_ers = 1'b1;
                end
            end
            ST_SENSE1: d.sen1   = 1'b1;
            ST_SENSE2: d.sen2   = 1'b1;
            ST_LATCH:  d.out_en = 4'hF;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/flash_array_ctrl_if.sv
// flash_array_ctrl_if: command/response handshake of the flash sequencer.
//   cmd_valid/cmd_ready, cmd_op[1:0], cmd_row[2:0], cmd_data[7:0]
//   rsp_valid/rsp_ready, rsp_data[7:0], rsp_fail
//   master = requester (bus/IO logic), slave = flash_array_ctrl
interface flash_array_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_row;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_fail;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_fail
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_fail
    );
endinterface

// File: rtl/flash_phase_timer.sv
// flash_phase_timer: loadable down-counter timing each sequencer phase.
//   clk, rst_n    : clock, async active-low reset
//   load/load_val : load N-1 when entering a timed phase
//   cnt           : current count
//   done          : count has reached 0 (phase ends on this cycle's edge)
module flash_phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (load)         cnt <= load_val;
        else if (cnt != '0)    cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/flash_array_ctrl.sv
// flash_array_ctrl: sequencer for the 8x8 NAND-style flash array macro.
//   wb_clk_i, wb_rst_n : clock, async active-low reset
//   bus (slave)        : command / response handshake
//   busy               : sequencer not idle
//   ssl_en, gsl_en     : string/ground select per block
//   wl_sel             : one-hot word line, index = block*4+wl
//   bl_en              : bit-line program drive (only while hv_pgm)
//   hv_pgm, hv_ers     : program / erase high-voltage enables
//   sen1, sen2, out_en : sense phases and array output enables
//   sense_in           : array read data
// Optional macro FLASH_CTRL_VERIFY_EN adds program-verify with up to
// MAX_RETRY extra pulses; without it rsp_fail is tied 0.
module flash_array_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int T_SETUP   = T_SETUP_DEF,
    parameter int T_PGM     = T_PGM_DEF,
    parameter int T_ERS     = T_ERS_DEF,
    parameter int T_SENSE   = T_SENSE_DEF,
    parameter int T_RECOV   = T_RECOV_DEF
`ifdef FLASH_CTRL_VERIFY_EN
    , parameter int MAX_RETRY = MAX_RETRY_DEF
`endif
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    flash_array_ctrl_if.slave   bus,
    output logic                busy,
    output logic [1:0]          ssl_en,
    output logic [1:0]          gsl_en,
    output logic [7:0]          wl_sel,
    output logic [7:0]          bl_en,
    output logic                hv_pgm,
    output logic                hv_ers,
    output logic                sen1,
    output logic                sen2,
    output logic [3:0]          out_en,
    input  logic [7:0]          sense_in
);

    localparam int T_MAX = max2(max2(max2(T_SETUP, T_PGM), max2(T_ERS, T_SENSE)), T_RECOV);
    localparam int CNT_W = $clog2(T_MAX) + 1;

    state_t             state, ns;
    cmd_t               cmd_q, cmd_nx;
    drive_t             drv;
    logic               cmd_ready_q, rsp_valid_q;
    logic [7:0]         rsp_data_q;
    logic               nop_pend;     // reserved op waits one cycle in IDLE
    logic               accept;
    logic               tmr_load, tmr_done;
    logic [CNT_W-1:0]   tmr_val, tmr_cnt;
    logic               vfy;          // current SETUP..RECOV pass is a verify read

`ifdef FLASH_CTRL_VERIFY_EN
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
    logic [RTY_W-1:0]   retry;
    logic               rsp_fail_q;
    logic               vfy_pass;
    logic               vfy_q;
    assign vfy      = vfy_q;
    // Every cell targeted by a 0 in the data must have read back 0.
    assign vfy_pass = ((rsp_data_q | cmd_q.data) == cmd_q.data);
`else
    assign vfy = 1'b0;
`endif

    assign accept = bus.cmd_valid && cmd_ready_q;
    assign cmd_nx = accept ? cmd_t'{op: op_t'(bus.cmd_op), row: bus.cmd_row, data: bus.cmd_data}
                           : cmd_q;

    flash_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .done     (tmr_done)
    );

    always_comb begin
        ns       = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (nop_pend) begin
                    ns = ST_DONE;
                end else if (accept && op_t'(bus.cmd_op) != OP_NOP) begin
                    ns       = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP - 1);
                end
            end
            ST_SETUP: if (tmr_done) begin
                tmr_load = 1'b1;
                if (cmd_q.op == OP_READ || vfy) begin
                    ns      = ST_SENSE1;
                    tmr_val = CNT_W'(T_SENSE - 1);
                end else begin
                    ns      = ST_PULSE;
                    tmr_val = (cmd_q.op == OP_PROGRAM) ? CNT_W'(T_PGM - 1) : CNT_W'(T_ERS - 1);
                end
            end
            ST_PULSE: if (tmr_done) begin
                ns       = ST_RECOV;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(T_RECOV - 1);
            end
            ST_SENSE1: if (tmr_done) begin
                ns       = ST_SENSE2;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(T_SENSE - 1);
            end
            ST_SENSE2: if (tmr_done) begin
                ns       = ST_LATCH;
                tmr_load = 1'b1;
                tmr_val  = '0;
            end
            ST_LATCH: if (tmr_done) begin
                ns       = ST_RECOV;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(T_RECOV - 1);
            end
            ST_RECOV: if (tmr_done) begin
                ns = ST_DONE;
`ifdef FLASH_CTRL_VERIFY_EN
                // After a pulse: verify. After a failed verify: pulse again
                // while retries remain.
                if (cmd_q.op == OP_PROGRAM &&
                    (!vfy || (!vfy_pass && retry < RTY_W'(MAX_RETRY)))) begin
                    ns       = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP - 1);
                end
`endif
            end
            ST_DONE: if (bus.rsp_ready) ns = ST_IDLE;
            default: ns = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so every drive changes on
    // the same edge as the state it belongs to.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            drv         <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy        <= 1'b0;
            nop_pend    <= 1'b0;
`ifdef FLASH_CTRL_VERIFY_EN
            vfy_q       <= 1'b0;
            retry       <= '0;
            rsp_fail_q  <= 1'b0;
`endif
        end else begin
            state       <= ns;
            drv         <= drive_of(ns, cmd_nx);
            cmd_ready_q <= (ns == ST_IDLE) && !accept;
            rsp_valid_q <= (ns == ST_DONE);
            busy        <= (ns != ST_IDLE);
            nop_pend    <= accept && (op_t'(bus.cmd_op) == OP_NOP);
            if (accept) begin
                cmd_q      <= cmd_nx;
                rsp_data_q <= '0;
            end
            if (state == ST_LATCH) rsp_data_q <= sense_in;
`ifdef FLASH_CTRL_VERIFY_EN
            if (accept) begin
                vfy_q      <= 1'b0;
                retry      <= '0;
                rsp_fail_q <= 1'b0;
            end
            if (state == ST_RECOV && tmr_done && cmd_q.op == OP_PROGRAM) begin
                if (!vfy_q) begin
                    vfy_q <= 1'b1;
                end else if (!vfy_pass) begin
                    if (retry < RTY_W'(MAX_RETRY)) begin
                        vfy_q <= 1'b0;
                        retry <= retry + 1'b1;
                    end else begin
                        rsp_fail_q <= 1'b1;
                    end
                end
            end
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
`ifdef FLASH_CTRL_VERIFY_EN
    assign bus.rsp_fail  = rsp_fail_q;
`else
    assign bus.rsp_fail  = 1'b0;
`endif

    assign ssl_en = drv.ssl_en;
    assign gsl_en = drv.gsl_en;
    assign wl_sel = drv.wl_sel;
    assign bl_en  = drv.bl_en;
    assign hv_pgm = drv.hv_pgm;
    assign hv_ers = drv.hv_ers;
    assign sen1   = drv.sen1;
    assign sen2   = drv.sen2;
    assign out_en = drv.out_en;

endmodule

// File: tb/tb_flash_array_ctrl.sv
// tb_flash_array_ctrl: self-checking bench for flash_array_ctrl.
// Expected drives are derived from the phase-length arithmetic of each op.
module tb_flash_array_ctrl;
    import flash_ctrl_pkg::*;

    localparam int TS  = T_SETUP_DEF;
    localparam int TP  = T_PGM_DEF;
    localparam int TE  = T_ERS_DEF;
    localparam int TSN = T_SENSE_DEF;
    localparam int TR  = T_RECOV_DEF;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_n = 1'b0;
    logic       busy;
    logic [1:0] ssl_en, gsl_en;
    logic [7:0] wl_sel, bl_en;
    logic       hv_pgm, hv_ers, sen1, sen2;
    logic [3:0] out_en;
    logic [7:0] sense_in;

    flash_array_ctrl_if bus();

    flash_array_ctrl dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .bus      (bus),
        .busy     (busy),
        .ssl_en   (ssl_en),
        .gsl_en   (gsl_en),
        .wl_sel   (wl_sel),
        .bl_en    (bl_en),
        .hv_pgm   (hv_pgm),
        .hv_ers   (hv_ers),
        .sen1     (sen1),
        .sen2     (sen2),
        .out_en   (out_en),
        .sense_in (sense_in)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] drv_now();
        return {ssl_en, gsl_en, wl_sel, bl_en, hv_pgm, hv_ers, sen1, sen2, out_en};
    endfunction

    // Cycles from the accept edge until rsp_valid is seen.
    function automatic int lat_of(int op);
        case (op)
            0:       return TS + 2*TSN + 1 + TR;
            1:       return TS + TP + TR;
            2:       return TS + TE + TR;
            default: return 1;
        endcase
    endfunction

    // Expected array drives in the k-th cycle after the accept edge.
    function automatic logic [27:0] exp_drv(int op, logic [2:0] row, logic [7:0] data, int k);
        logic [1:0] sel;
        logic [7:0] wl, bl;
        logic       hp, he, s1, s2;
        logic [3:0] oe;
        int         sel_end;
        sel = '0; wl = '0; bl = '0; hp = 0; he = 0; s1 = 0; s2 = 0; oe = '0;
        case (op)
            0:       sel_end = TS + 2*TSN + 1;
            1:       sel_end = TS + TP;
            2:       sel_end = TS + TE;
            default: sel_end = 0;
        endcase
        if (k < sel_end) begin
            sel = 2'(1 << row[2]);
            if (op != 2) wl = 8'(1 << row);
        end
        if (op == 1 && k >= TS && k < TS + TP) begin hp = 1; bl = ~data; end
        if (op == 2 && k >= TS && k < TS + TE) he = 1;
        if (op == 0) begin
            s1 = (k >= TS) && (k < TS + TSN);
            s2 = (k >= TS + TSN) && (k < TS + 2*TSN);
            oe = (k == TS + 2*TSN) ? 4'hF : 4'h0;
        end
        return {sel, sel, wl, bl, hp, he, s1, s2, oe};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_cmd(int op, logic [2:0] row, logic [7:0] data,
                           logic [7:0] sense, int hold);
        int lat;
        lat      = lat_of(op);
        sense_in = sense;
        check("ready_pre", bus.cmd_ready, 1);
        bus.cmd_valid = 1; bus.cmd_op = 2'(op); bus.cmd_row = row; bus.cmd_data = data;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        bus.cmd_valid = 0;
        for (int k = 0; k <= lat + hold; k++) begin
            check($sformatf("drv op%0d k%0d", op, k), drv_now(), exp_drv(op, row, data, k));
            check($sformatf("stat op%0d k%0d", op, k), {bus.rsp_valid, busy, bus.cmd_ready},
                  {k >= lat, (op != 3) || (k >= 1), 1'b0});
            if (k >= lat)
                check($sformatf("rsp op%0d k%0d", op, k), {bus.rsp_fail, bus.rsp_data},
                      {1'b0, (op == 0) ? sense : 8'h00});
            if (k >= lat && k < lat + hold) begin
                // Stray request while the response is pending must be ignored.
                bus.cmd_valid = 1; bus.cmd_op = 2'($urandom); bus.cmd_row = 3'($urandom);
            end
            if (k == lat + hold) begin
                bus.cmd_valid = 0;
                bus.rsp_ready = 1;
            end
            @(negedge wb_clk_i);
        end
        bus.rsp_ready = 0;
        check("post_stat", {bus.rsp_valid, busy, bus.cmd_ready}, 3'b001);
        check("post_drv", drv_now(), 28'h0);
    endtask

`ifdef FLASH_CTRL_VERIFY_EN
    task automatic run_vfy(logic [2:0] row, logic [7:0] data, logic [7:0] sense);
        int   pulses, cyc, exp_pulses;
        logic prev, pass;
        pass       = ((sense | data) == data);
        exp_pulses = pass ? 1 : 1 + MAX_RETRY_DEF;
        pulses = 0; cyc = 0; prev = 0;
        sense_in = sense;
        bus.cmd_valid = 1; bus.cmd_op = 2'd1; bus.cmd_row = row; bus.cmd_data = data;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        bus.cmd_valid = 0;
        while (!bus.rsp_valid && cyc < 2000) begin
            if (hv_pgm && !prev) pulses++;
            prev = hv_pgm;
            @(negedge wb_clk_i);
            cyc++;
        end
        check("vfy_timeout", cyc < 2000, 1);
        check("vfy_pulses", pulses, exp_pulses);
        check("vfy_fail", bus.rsp_fail, !pass);
        check("vfy_data", bus.rsp_data, sense);
        bus.rsp_ready = 1;
        @(negedge wb_clk_i);
        bus.rsp_ready = 0;
        check("vfy_post", {bus.rsp_valid, busy, bus.cmd_ready}, 3'b001);
    endtask
`endif

    initial begin
        int op;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_row = 0; bus.cmd_data = 0;
        bus.rsp_ready = 0; sense_in = 0;
        #12;
        check("rst_stat", {bus.cmd_ready, bus.rsp_valid, busy, bus.rsp_fail, bus.rsp_data}, 12'h800);
        check("rst_drv", drv_now(), 28'h0);
        @(negedge wb_clk_i);
        wb_rst_n = 1;
        @(negedge wb_clk_i);

        // Directed: READ row 5, PROGRAM row 2, ERASE block 1, held response.
        run_cmd(0, 3'd5, 8'h00, 8'hA5, 0);
`ifndef FLASH_CTRL_VERIFY_EN
        run_cmd(1, 3'd2, 8'h0F, 8'h00, 0);
`endif
        run_cmd(2, 3'd4, 8'h00, 8'h00, 0);
        run_cmd(0, 3'd1, 8'h00, 8'h3C, 10);
        run_cmd(3, 3'd7, 8'hFF, 8'hFF, 2);

        // Reset in the middle of a program pulse.
        sense_in = 0;
        bus.cmd_valid = 1; bus.cmd_op = 2'd1; bus.cmd_row = 3'd2; bus.cmd_data = 8'h0F;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        bus.cmd_valid = 0;
        repeat (8) @(negedge wb_clk_i);
        check("pulse_hv", {hv_pgm, bl_en, wl_sel}, {1'b1, 8'hF0, 8'h04});
        #2 wb_rst_n = 0;
        #1;
        check("rst_hv", hv_pgm, 0);
        check("rst_mid_drv", drv_now(), 28'h0);
        check("rst_mid_stat", {bus.cmd_ready, busy, bus.rsp_valid}, 3'b100);
        @(negedge wb_clk_i);
        wb_rst_n = 1;
        @(negedge wb_clk_i);
        check("rst_idle", {bus.cmd_ready, busy}, 2'b10);

`ifdef FLASH_CTRL_VERIFY_EN
        run_vfy(3'd3, 8'h00, 8'h01);
        run_vfy(3'd6, 8'h00, 8'h00);
        run_vfy(3'd0, 8'h5A, 8'h5A);
`endif

        // Randomized commands.
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 3);
`ifdef FLASH_CTRL_VERIFY_EN
            if (op == 1) op = 0;
`endif
            run_cmd(op, 3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
